// File: rtl/gppcu_cmd_sched.sv
// Two-requester command scheduler for the GPPCU queue port: round-robin arbitration,
// then a setup/strobe/hold sequence on oCMD with an optional one-word read response.
module gppcu_cmd_sched #(
    parameter int SETUP_CYC = 1,
    parameter int HIGH_CYC  = 1
) (
    input  logic        iACLK,
    input  logic        iRST,
    input  logic        iA_VALID,
    output logic        oA_READY,
    input  logic [30:0] iA_CMD,
    input  logic [31:0] iA_DATA,
    output logic        oA_RVALID,
    output logic [31:0] oA_RDATA,
    input  logic        iB_VALID,
    output logic        oB_READY,
    input  logic [30:0] iB_CMD,
    input  logic [31:0] iB_DATA,
    output logic        oB_RVALID,
    output logic [31:0] oB_RDATA,
    output logic [31:0] oCMD,
    output logic [31:0] oDATA,
    input  logic [31:0] iRDATA,
    output logic        oBUSY,
    output logic        oGRANT_B,
    output logic [15:0] oCMD_CNT
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] HIGH_LAST  = 4'(HIGH_CYC - 1);

    state_t     state, state_nxt;
    logic [3:0] cyc_cnt;
    logic       pick_b, accept, is_read;

    // Only wparam 1 and 4 return data from the queue.
    assign is_read = (oCMD[30:24] == 7'd1) || (oCMD[30:24] == 7'd4);

    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST)                                cyc_cnt <= '0;
        else if (state_nxt != state)             cyc_cnt <= '0;
        else if (state == SETUP || state == STROBE) cyc_cnt <= cyc_cnt + 4'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (cyc_cnt == SETUP_LAST) state_nxt = STROBE;
            STROBE:  if (cyc_cnt == HIGH_LAST) state_nxt = HOLD;
            HOLD:    state_nxt = is_read ? RESP : IDLE;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Under contention the requester that did not own the last transfer wins.
    always_comb begin
        pick_b   = (iA_VALID && iB_VALID) ? ~oGRANT_B : iB_VALID;
        oA_READY = (state == IDLE) && iA_VALID && !pick_b;
        oB_READY = (state == IDLE) && iB_VALID && pick_b;
        accept   = oA_READY || oB_READY;
    end

    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            oCMD      <= '0;
            oDATA     <= '0;
            oBUSY     <= 1'b0;
            oGRANT_B  <= 1'b1;
            oCMD_CNT  <= '0;
            oA_RVALID <= 1'b0;
            oB_RVALID <= 1'b0;
            oA_RDATA  <= '0;
            oB_RDATA  <= '0;
        end else begin
            oA_RVALID <= 1'b0;
            oB_RVALID <= 1'b0;
            oBUSY     <= (state_nxt != IDLE);
            oCMD[31]  <= (state_nxt == STROBE);
            if (state_nxt == STROBE && state != STROBE)
                oCMD_CNT <= oCMD_CNT + 16'd1;
            if (accept) begin
                oCMD[30:0] <= pick_b ? iB_CMD : iA_CMD;
                oDATA      <= pick_b ? iB_DATA : iA_DATA;
                oGRANT_B   <= pick_b;
            end
            // Fields stay latched through IDLE so the queue sees the last command.
            if (state == RESP) begin
                if (oGRANT_B) begin
                    oB_RDATA  <= iRDATA;
                    oB_RVALID <= 1'b1;
                end else begin
                    oA_RDATA  <= iRDATA;
                    oA_RVALID <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gppcu_cmd_sched.sv
// Bench for gppcu_cmd_sched: transaction-phase reference model, vector table,
// directed corner sequences and randomized traffic.
module tb_gppcu_cmd_sched;
    localparam int S = 1;
    localparam int H = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_v, b_v;
    logic [30:0] a_cmd, b_cmd;
    logic [31:0] a_data, b_data, rdata;
    logic        a_rdy, b_rdy, a_rv, b_rv, busy, grant_b;
    logic [31:0] a_rd, b_rd, cmd_o, data_o;
    logic [15:0] cnt;

    logic        a2_v;
    logic [30:0] a2_cmd;
    logic [31:0] a2_data;
    logic        b2_v = 1'b0;
    logic [30:0] b2_cmd = '0;
    logic [31:0] b2_data = '0;
    logic        a2_rdy, b2_rdy, a2_rv, b2_rv, busy2, grant2;
    logic [31:0] a2_rd, b2_rd, cmd2, data2;
    logic [15:0] cnt2;

    always #5 clk = ~clk;

    gppcu_cmd_sched dut (
        .iACLK(clk), .iRST(rst),
        .iA_VALID(a_v), .oA_READY(a_rdy), .iA_CMD(a_cmd), .iA_DATA(a_data),
        .oA_RVALID(a_rv), .oA_RDATA(a_rd),
        .iB_VALID(b_v), .oB_READY(b_rdy), .iB_CMD(b_cmd), .iB_DATA(b_data),
        .oB_RVALID(b_rv), .oB_RDATA(b_rd),
        .oCMD(cmd_o), .oDATA(data_o), .iRDATA(rdata),
        .oBUSY(busy), .oGRANT_B(grant_b), .oCMD_CNT(cnt)
    );

    gppcu_cmd_sched #(.SETUP_CYC(3), .HIGH_CYC(2)) dut2 (
        .iACLK(clk), .iRST(rst),
        .iA_VALID(a2_v), .oA_READY(a2_rdy), .iA_CMD(a2_cmd), .iA_DATA(a2_data),
        .oA_RVALID(a2_rv), .oA_RDATA(a2_rd),
        .iB_VALID(b2_v), .oB_READY(b2_rdy), .iB_CMD(b2_cmd), .iB_DATA(b2_data),
        .oB_RVALID(b2_rv), .oB_RDATA(b2_rd),
        .oCMD(cmd2), .oDATA(data2), .iRDATA(rdata),
        .oBUSY(busy2), .oGRANT_B(grant2), .oCMD_CNT(cnt2)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_p counts cycles since the accepting edge (0 = idle).
    int          m_p;
    bit          m_read, m_own_b, m_last_b;
    logic [31:0] e_cmd, e_data, e_rd_a, e_rd_b;
    bit          e_rv_a, e_rv_b, e_rdy_a, e_rdy_b;
    logic [15:0] e_cnt;

    task automatic model_reset();
        m_p = 0; m_read = 0; m_own_b = 0; m_last_b = 1;
        e_cmd = '0; e_data = '0; e_rd_a = '0; e_rd_b = '0;
        e_rv_a = 0; e_rv_b = 0; e_cnt = '0;
    endtask

    task automatic model_edge(input bit acc_a, input bit acc_b);
        logic [6:0] wp;
        e_rv_a = 0; e_rv_b = 0;
        if (m_read && m_p == S + H + 2) begin
            if (m_own_b) begin e_rd_b = rdata; e_rv_b = 1; end
            else         begin e_rd_a = rdata; e_rv_a = 1; end
        end
        if (acc_a || acc_b) begin
            m_p = 1; m_own_b = acc_b; m_last_b = acc_b;
            e_cmd[30:0] = acc_b ? b_cmd : a_cmd;
            e_data      = acc_b ? b_data : a_data;
            wp = e_cmd[30:24];
            m_read = (wp == 7'd1) || (wp == 7'd4);
        end else if (m_p > 0) begin
            m_p++;
            if (m_p > S + H + 1 + int'(m_read)) m_p = 0;
        end
        if (m_p == S + 1) e_cnt++;
        e_cmd[31] = (m_p >= S + 1) && (m_p <= S + H);
    endtask

    logic [31:0] smp_cmd;
    bit          smp_rva, smp_rvb, smp_s2, smp_rdy2;
    bit          gq[$];

    task automatic check_all();
        chk("cmd", cmd_o, e_cmd);
        chk("data", data_o, e_data);
        chk("busy", busy, m_p != 0);
        chk("grant_b", grant_b, m_last_b);
        chk("cmd_cnt", cnt, e_cnt);
        chk("a_ready", a_rdy, e_rdy_a);
        chk("b_ready", b_rdy, e_rdy_b);
        chk("a_rvalid", a_rv, e_rv_a);
        chk("b_rvalid", b_rv, e_rv_b);
        chk("a_rdata", a_rd, e_rd_a);
        chk("b_rdata", b_rd, e_rd_b);
    endtask

    // One clock: check at negedge, step model at posedge, drop accepted VALIDs after it.
    task automatic cycle();
        bit acc_a, acc_b, pb;
        @(negedge clk);
        pb = (a_v && b_v) ? !m_last_b : b_v;
        e_rdy_a = (m_p == 0) && a_v && !pb;
        e_rdy_b = (m_p == 0) && b_v && pb;
        check_all();
        smp_cmd = cmd_o; smp_rva = a_rv; smp_rvb = b_rv;
        smp_s2 = cmd2[31]; smp_rdy2 = a2_rdy;
        if (a_rdy && a_v) gq.push_back(1'b0);
        if (b_rdy && b_v) gq.push_back(1'b1);
        acc_a = a_v && e_rdy_a;
        acc_b = b_v && e_rdy_b;
        @(posedge clk);
        model_edge(acc_a, acc_b);
        #1;
        if (acc_a) a_v = 1'b0;
        if (acc_b) b_v = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [30:0] rcmd();
        logic [6:0] wp;
        case ($urandom_range(0, 3))
            0:       wp = 7'd1;
            1:       wp = 7'd4;
            default: wp = 7'($urandom);
        endcase
        return {wp, 24'($urandom)};
    endfunction

    typedef struct {
        bit          use_b;
        logic [30:0] cmd;
        logic [31:0] data;
        logic [31:0] rd;
        logic [5:0]  strb;
        logic [5:0]  rva;
        logic [5:0]  rvb;
        logic [31:0] exp_rda;
        logic [31:0] exp_rdb;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [5:0] strb, rva, rvb;
        logic [7:0] s2;

        tbl[0] = '{0, 31'h0300_0005, 32'hDEAD_BEEF, 32'h1234_5678, 6'b000010, 6'b0, 6'b0,        32'h0,         32'h0,         16'd1};
        tbl[1] = '{1, 31'h0400_0010, 32'h0000_0000, 32'h8000_0000, 6'b000010, 6'b0, 6'b010000,   32'h0,         32'h8000_0000, 16'd2};
        tbl[2] = '{1, 31'h0100_0000, 32'h0000_1111, 32'h0BAD_F00D, 6'b000010, 6'b0, 6'b010000,   32'h0,         32'h0BAD_F00D, 16'd3};
        tbl[3] = '{0, 31'h0112_0042, 32'h0000_2222, 32'hA5A5_0001, 6'b000010, 6'b010000, 6'b0,   32'hA5A5_0001, 32'h0BAD_F00D, 16'd4};
        tbl[4] = '{0, 31'h0200_0001, 32'h0000_3333, 32'hFFFF_FFFF, 6'b000010, 6'b0, 6'b0,        32'hA5A5_0001, 32'h0BAD_F00D, 16'd5};
        tbl[5] = '{1, 31'h0500_00FF, 32'h0000_4444, 32'h0000_0001, 6'b000010, 6'b0, 6'b0,        32'hA5A5_0001, 32'h0BAD_F00D, 16'd6};
        tbl[6] = '{0, 31'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0002, 6'b000010, 6'b0, 6'b0,        32'hA5A5_0001, 32'h0BAD_F00D, 16'd7};

        rst = 1'b1;
        a_v = 0; b_v = 0; a_cmd = '0; b_cmd = '0; a_data = '0; b_data = '0; rdata = '0;
        a2_v = 0; a2_cmd = '0; a2_data = '0;
        #12;
        chk("rst_cmd", cmd_o, 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_b", grant_b, 1'b1);
        chk("rst_cnt", cnt, 16'h0);
        chk("rst_rvalid", {a_rv, b_rv}, 2'b00);
        chk("rst_rdata", a_rd | b_rd, 32'h0);
        do_reset();

        // Stretched timing instance: strobe in cycles 4 and 5 after the accept.
        a2_v = 1; a2_cmd = 31'h0300_0001; a2_data = 32'h5555_AAAA;
        cycle();
        chk("p2_ready", smp_rdy2, 1'b1);
        a2_v = 0;
        s2 = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            s2[k] = smp_s2;
        end
        chk("p2_strobe_cycles", s2, 8'h18);
        chk("p2_cnt", cnt2, 16'd1);
        chk("p2_busy", busy2, 1'b0);

        for (int i = 0; i < 7; i++) begin
            rdata = tbl[i].rd;
            if (tbl[i].use_b) begin b_v = 1; b_cmd = tbl[i].cmd; b_data = tbl[i].data; end
            else              begin a_v = 1; a_cmd = tbl[i].cmd; a_data = tbl[i].data; end
            cycle();
            strb = '0; rva = '0; rvb = '0;
            for (int k = 0; k < 6; k++) begin
                cycle();
                strb[k] = smp_cmd[31]; rva[k] = smp_rva; rvb[k] = smp_rvb;
                if (k < 3) chk("vec_fields", {1'b0, smp_cmd[30:0]}, {1'b0, tbl[i].cmd});
            end
            chk("vec_strobe", strb, tbl[i].strb);
            chk("vec_a_rvalid", rva, tbl[i].rva);
            chk("vec_b_rvalid", rvb, tbl[i].rvb);
            chk("vec_a_rdata", a_rd, tbl[i].exp_rda);
            chk("vec_b_rdata", b_rd, tbl[i].exp_rdb);
            chk("vec_cnt", cnt, tbl[i].exp_cnt);
            chk("vec_grant_b", grant_b, tbl[i].use_b);
        end

        // Reset while a read is strobing; afterwards a waiting A request goes through.
        a_v = 1; a_cmd = 31'h0100_0007; a_data = 32'h7777_0000; rdata = 32'hCAFE_0001;
        cycle();
        cycle();
        #2;
        chk("pre_rst_strobe", cmd_o[31], 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_cmd", cmd_o, 32'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cnt", cnt, 16'h0);
        chk("midrst_rvalid", {a_rv, b_rv}, 2'b00);
        a_v = 1; a_cmd = 31'h0200_0099; a_data = 32'h0BEE_0BEE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        gq.delete();
        for (int k = 0; k < 7; k++) cycle();
        chk("postrst_grants", gq.size(), 1);
        if (gq.size() > 0) chk("postrst_owner", gq[0], 1'b0);
        chk("postrst_cnt", cnt, 16'd1);

        // Contention right after reset: A first, then strict alternation.
        do_reset();
        gq.delete();
        for (int k = 0; k < 80 && gq.size() < 8; k++) begin
            if (!a_v) begin a_v = 1; a_cmd = {7'd2, 24'($urandom)}; a_data = $urandom; end
            if (!b_v) begin b_v = 1; b_cmd = {7'd3, 24'($urandom)}; b_data = $urandom; end
            cycle();
        end
        a_v = 0; b_v = 0;
        for (int k = 0; k < 4; k++) cycle();
        chk("cont_grants", gq.size(), 8);
        for (int i = 0; i < gq.size() && i < 8; i++) chk("cont_order", gq[i], 32'(i % 2));
        chk("cont_cnt", cnt, 16'd8);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if (!a_v && $urandom_range(0, 2) == 0) begin a_v = 1; a_cmd = rcmd(); a_data = $urandom; end
            if (!b_v && $urandom_range(0, 2) == 0) begin b_v = 1; b_cmd = rcmd(); b_data = $urandom; end
            rdata = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gppcu_cmd_sched.md
GPPCU_CMD_SCHED -- requirements
Module: gppcu_cmd_sched

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles the command fields are driven with strobe low before the strobe; legal range 1-15.
REQ-002 Parameter HIGH_CYC, default 1: cycles the strobe (oCMD[31]) is high; legal range 1-15.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 iACLK  in  1  clock.
REQ-005 iRST  in  1  asynchronous active-high reset.
REQ-006 iA_VALID, oA_READY  in/out  1/1  requester A command handshake.
REQ-007 iA_CMD, iA_DATA  in  31/32  requester A command {wparam[30:24], lparam[23:16], command[15:0]} and write data.
REQ-008 oA_RVALID, oA_RDATA  out  1/32  requester A read response.
REQ-009 iB_VALID, oB_READY, iB_CMD, iB_DATA, oB_RVALID, oB_RDATA: same as REQ-006 to REQ-008, for requester B.
REQ-010 oCMD  out  32  {strobe, wparam, lparam, command} to the queue command port.
REQ-011 oDATA  out  32  write data to the queue.
REQ-012 iRDATA  in  32  queue read data/status.
REQ-013 oBUSY  out  1  high in any state other than IDLE.
REQ-014 oGRANT_B  out  1  owner of the current or last transfer (0=A, 1=B).
REQ-015 oCMD_CNT  out  16  count of issued strobes.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD and RESP.
REQ-017 In IDLE, exactly one READY SHALL be high, combinationally, for the granted requester only when that requester's VALID is high.
REQ-018 Arbitration:
- A sole requester SHALL win.
- When both are valid, the requester not granted last SHALL win (round-robin).
REQ-019 On VALID&READY the block SHALL register CMD, DATA and the owner, and move to SETUP.
REQ-020 In SETUP, oCMD[30:0] and oDATA SHALL carry the latched values with oCMD[31]=0 for SETUP_CYC cycles; then the FSM moves to STROBE.
REQ-021 In STROBE, oCMD[31]=1 for HIGH_CYC cycles; oCMD_CNT SHALL increment (mod 2^16) once on STROBE entry.
REQ-022 In HOLD, the block SHALL drive oCMD[31]=0 with fields unchanged for exactly 1 cycle.
REQ-023 From HOLD, the FSM SHALL go to RESP if wparam is 1 or 4, otherwise to IDLE.
REQ-024 RESP lasts 1 cycle:
- iRDATA SHALL be registered into the owner's RDATA.
- The owner's RVALID SHALL pulse high for exactly the following cycle.
- The FSM then returns to IDLE.
REQ-025 A non-owner RDATA SHALL hold its previous value.
REQ-026 Any other wparam value (0, 2, 3, 5-127) SHALL be issued as a write with no response.
REQ-027 Requesters SHALL hold VALID and CMD stable until READY; the block SHALL NOT sample VALID outside IDLE.
REQ-028 oCMD[30:0] and oDATA SHALL hold the last issued values while in IDLE.
REQ-029 All outputs except READY SHALL be registered.
REQ-030 Latency with defaults:
- Write: accept at edge 0, strobe high during cycle 2, next accept possible at edge 4.
- Read: RVALID high during cycle 5.

Reset
REQ-031 iRST SHALL force, asynchronously: FSM=IDLE, oCMD=0, oDATA=0, both RVALID=0, both RDATA=0, oCMD_CNT=0, oGRANT_B=1 (so A wins first), oBUSY=0.
REQ-032 A reset during STROBE SHALL drop oCMD[31] immediately, discard the in-flight command, and produce no RVALID.

Verification
REQ-033 Single write: A issues CMD=0x03_00_0005, DATA=0xDEADBEEF -> oCMD[31] high exactly 1 cycle at cycle 2, fields stable cycles 1-3, no RVALID, oCMD_CNT=1.
REQ-034 Read: B issues wparam=4, lparam=0 with iRDATA=0x80000000 -> oB_RVALID pulses 1 cycle with oB_RDATA=0x80000000; oA_RVALID stays 0.
REQ-035 Contention: A and B valid continuously for 4 writes each -> grants alternate A,B,A,B..., with A first after reset and oCMD_CNT=8.
REQ-036 Parameters SETUP_CYC=3, HIGH_CYC=2 -> strobe rises 3 cycles after accept and stays high 2 cycles.
REQ-037 Reset asserted mid-STROBE -> oCMD=0 at once, no RVALID; after release, a pending A request is accepted normally.
REQ-038 Counter wrap: 65536 writes -> oCMD_CNT returns to 0.
